// File: rtl/frame_rd_ctrl.sv
// Frame-buffer read controller: streams BRAM port-B addresses frame by frame and
// pushes returned pixels into the output FIFO, aligned to the BRAM read latency.
module frame_rd_ctrl #(
    parameter int unsigned BRAM_DEPTH = 307200,
    parameter int unsigned ADDR_WIDTH = 19,
    parameter int unsigned RD_LATENCY = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_flush,
    input  logic                  i_req,
    output logic [ADDR_WIDTH-1:0] o_raddr,
    output logic                  o_ren,
    output logic                  o_wr,
    output logic                  o_sof,
    input  logic                  i_almostfull,
    output logic                  o_busy
);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(BRAM_DEPTH - 1);

    state_t                state;
    logic [RD_LATENCY-1:0] vld_pipe;
    logic [RD_LATENCY-1:0] sof_pipe;
    logic                  at_last;

    // Throttle is combinational so almost-full stops reads in the same cycle;
    // only reads already in flight can land after it rises.
    always_comb begin
        o_ren   = (state == ACTIVE) && !i_almostfull;
        at_last = (o_raddr == LAST_ADDR);
        o_wr    = vld_pipe[RD_LATENCY-1];
        o_sof   = sof_pipe[RD_LATENCY-1];
        o_busy  = (state == ACTIVE) || (|vld_pipe);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= IDLE;
            o_raddr  <= '0;
            vld_pipe <= '0;
            sof_pipe <= '0;
        end else if (i_flush) begin
            state    <= IDLE;
            o_raddr  <= '0;
            vld_pipe <= '0;
            sof_pipe <= '0;
        end else begin
            // Pipeline shifts in every state so in-flight reads always drain.
            for (int unsigned i = RD_LATENCY - 1; i > 0; i--) begin
                vld_pipe[i] <= vld_pipe[i-1];
                sof_pipe[i] <= sof_pipe[i-1];
            end
            vld_pipe[0] <= o_ren;
            sof_pipe[0] <= o_ren && (o_raddr == '0);

            case (state)
                IDLE: begin
                    o_raddr <= '0;
                    if (i_req) begin
                        state <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (o_ren) begin
                        if (at_last) begin
                            o_raddr <= '0;
                            if (!i_req) begin
                                state <= IDLE;
                            end
                        end else begin
                            o_raddr <= o_raddr + 1'b1;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    o_raddr <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_rd_ctrl.sv
// Directed bench for frame_rd_ctrl: 16-pixel frames, 2-cycle BRAM model returning data=addr.
module tb_frame_rd_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       req;
    logic       af;
    logic [3:0] raddr;
    logic       ren;
    logic       wr;
    logic       sof;
    logic       busy;
    logic [3:0] p1;
    logic [3:0] p2;

    int checks   = 0;
    int failures = 0;
    int sof_cnt  = 0;
    int last_sof = -1;

    always #5 clk = ~clk;

    frame_rd_ctrl #(
        .BRAM_DEPTH(16),
        .ADDR_WIDTH(4),
        .RD_LATENCY(2)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_flush     (flush),
        .i_req       (req),
        .o_raddr     (raddr),
        .o_ren       (ren),
        .o_wr        (wr),
        .o_sof       (sof),
        .i_almostfull(af),
        .o_busy      (busy)
    );

    // BRAM port B: data = address presented two cycles earlier
    always @(posedge clk) begin
        p1 <= raddr;
        p2 <= p1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; req = 1'b0; af = 1'b0;
        step(); step(); #1;
        chk("rst_addr", raddr, 0);
        chk("rst_ren", ren, 0);
        chk("rst_wr", wr, 0);
        chk("rst_sof", sof, 0);
        chk("rst_busy", busy, 0);

        // release with request: transition cycle issues no read
        step(); rst = 1'b0; req = 1'b1; #1;
        chk("idle_ren", ren, 0);
        chk("idle_addr", raddr, 0);

        // three back-to-back frames
        for (int n = 0; n < 48; n++) begin
            step(); #1;
            chk("a_ren", ren, 1);
            chk("a_addr", raddr, n % 16);
            if (n >= 2) begin
                chk("a_wr", wr, 1);
                chk("a_data", p2, (n - 2) % 16);
                chk("a_sof", sof, ((n - 2) % 16 == 0) ? 1 : 0);
            end else begin
                chk("a_wr_lat", wr, 0);
            end
            if (sof) begin
                if (last_sof >= 0) chk("sof_gap", n - last_sof, 16);
                last_sof = n;
                sof_cnt++;
            end
        end
        chk("sof_count", sof_cnt, 3);

        // fourth frame, addresses 0..5
        for (int n = 48; n < 54; n++) begin
            step(); #1;
            chk("b_ren", ren, 1);
            chk("b_addr", raddr, n % 16);
            chk("b_wr", wr, 1);
            chk("b_data", p2, (n - 2) % 16);
        end

        // almost-full for 5 cycles at address 6
        step();
        chk("af_addr_pre", raddr, 6);
        af = 1'b1; #1;
        chk("af_ren0", ren, 0);
        chk("af_wr0", wr, 1);
        chk("af_data0", p2, 4);
        for (int t = 1; t < 5; t++) begin
            step(); #1;
            chk("af_ren", ren, 0);
            chk("af_addr", raddr, 6);
            chk("af_wr", wr, (t == 1) ? 1 : 0);
            if (t == 1) chk("af_data1", p2, 5);
        end
        step(); af = 1'b0; #1;
        chk("res_ren", ren, 1);
        chk("res_addr", raddr, 6);
        chk("res_wr", wr, 0);

        // resume, drop request at address 9; frame must still finish
        for (int t = 6; t < 15; t++) begin
            step();
            if (t == 8) req = 1'b0;
            #1;
            chk("c_ren", ren, 1);
            chk("c_addr", raddr, t + 1);
            chk("c_wr", wr, (t >= 7) ? 1 : 0);
            if (t >= 7) chk("c_data", p2, t - 1);
        end
        step(); #1;
        chk("eof_ren", ren, 0);
        chk("eof_addr", raddr, 0);
        chk("eof_wr", wr, 1);
        chk("eof_data", p2, 14);
        chk("eof_busy", busy, 1);
        step(); #1;
        chk("eof_wr2", wr, 1);
        chk("eof_data2", p2, 15);
        chk("eof_sof2", sof, 0);
        chk("eof_busy2", busy, 1);
        step(); #1;
        chk("idle_wr", wr, 0);
        chk("idle_busy", busy, 0);
        chk("idle_ren2", ren, 0);

        // restart, flush at address 10 with reads in flight
        req = 1'b1;
        for (int u = 1; u < 12; u++) begin
            step(); #1;
            chk("d_ren", ren, 1);
            chk("d_addr", raddr, u - 1);
            if (u >= 3) chk("d_data", p2, u - 3);
        end
        chk("d_wr_inflight", wr, 1);
        flush = 1'b1;
        step(); #1;
        chk("fl_addr", raddr, 0);
        chk("fl_ren", ren, 0);
        chk("fl_wr", wr, 0);
        chk("fl_sof", sof, 0);
        chk("fl_busy", busy, 0);
        step(); flush = 1'b0; #1;
        chk("fl_hold_ren", ren, 0);
        chk("fl_hold_addr", raddr, 0);
        step(); #1;
        chk("rs_ren", ren, 1);
        chk("rs_addr", raddr, 0);
        chk("rs_wr", wr, 0);
        step(); #1;
        chk("rs_addr1", raddr, 1);
        chk("rs_wr1", wr, 0);
        step(); #1;
        chk("rs_wr2", wr, 1);
        chk("rs_data", p2, 0);
        chk("rs_sof", sof, 1);
        chk("rs_addr2", raddr, 2);

        // async reset between edges mid-frame
        for (int u = 17; u < 21; u++) step();
        chk("ar_addr_pre", raddr, 6);
        #2; rst = 1'b1; #1;
        chk("ar_addr", raddr, 0);
        chk("ar_ren", ren, 0);
        chk("ar_wr", wr, 0);
        chk("ar_sof", sof, 0);
        chk("ar_busy", busy, 0);
        step(); rst = 1'b0; #1;
        chk("ar_idle_ren", ren, 0);
        chk("ar_idle_busy", busy, 0);
        step(); #1;
        chk("ar_ren1", ren, 1);
        chk("ar_addr1", raddr, 0);
        step(); #1;
        chk("ar_wr_lat", wr, 0);
        step(); #1;
        chk("ar_wr", wr, 1);
        chk("ar_data", p2, 0);
        chk("ar_sof1", sof, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/frame_rd_ctrl.md
Name: frame_rd_ctrl

Overview:
- BRAM frame-buffer read controller: the read-side counterpart of the camera write path.
- Issues sequential read addresses into the dual-port frame BRAM (port B).
- Tracks BRAM read latency and pushes each returned pixel into the 125→25 MHz output FIFO, throttled by the FIFO almost-full flag.
- Streams whole frames, address 0 to BRAM_DEPTH-1, for as long as the display requests pixels.

Parameters:
- BRAM_DEPTH, 307200, pixels per frame (640x480); addresses 0..BRAM_DEPTH-1.
- ADDR_WIDTH, 19, width of o_raddr; must satisfy 2^ADDR_WIDTH >= BRAM_DEPTH.
- RD_LATENCY, 2, BRAM port-B read latency in cycles, from address presented to doutb valid; legal range 1..4.

Ports:
- i_clk  in  1  125 MHz system clock.
- i_rst  in  1  asynchronous active-high reset.
- i_flush  in  1  synchronous abort; returns the block to its start-of-frame state.
- i_req  in  1  display active request (level, from the 25 MHz domain, already synchronised).
- o_raddr  out  ADDR_WIDTH  BRAM port-B read address.
- o_ren  out  1  BRAM port-B read enable; high when o_raddr is a real read this cycle.
- o_wr  out  1  FIFO write enable; aligned with valid BRAM doutb (doutb drives FIFO wdata directly).
- o_sof  out  1  one-cycle pulse coincident with the o_wr of pixel address 0.
- i_almostfull  in  1  FIFO almost-full flag.
- o_busy  out  1  high in ACTIVE or while any read is in flight.

Behaviour:
- Reset (i_rst high, async):
  - o_raddr=0, o_ren=0, o_wr=0, o_sof=0, o_busy=0.
  - Valid pipeline cleared; state=IDLE.
- States: IDLE, ACTIVE.
- IDLE:
  - o_raddr held at 0, o_ren=0.
  - When i_req=1, move to ACTIVE next cycle; no read is issued in the transition cycle.
- ACTIVE:
  - Each cycle with i_almostfull=0: o_ren=1 and the current o_raddr is read; o_raddr increments next cycle.
  - Each cycle with i_almostfull=1: o_ren=0 and o_raddr holds.
- End of frame: on the read of address BRAM_DEPTH-1, o_raddr wraps to 0.
  - If i_req=1 that cycle, stay in ACTIVE and continue with no bubble.
  - If i_req=0, go to IDLE.
  - i_req is only examined at frame end and in IDLE; dropping it mid-frame does not stop the frame.
- Latency pipeline:
  - RD_LATENCY-deep shift register of {ren, addr==0}.
  - o_wr = ren delayed exactly RD_LATENCY cycles.
  - o_sof = (ren && addr==0) delayed exactly RD_LATENCY cycles.
  - The pipeline keeps shifting in every state, so in-flight reads always complete after throttling or a return to IDLE.
- Almost-full contract: the FIFO asserts almost-full with at least RD_LATENCY+1 free entries. The block never writes a full FIFO under that contract; up to RD_LATENCY writes may land after almost-full rises.
- o_busy = (state==ACTIVE) OR any pipeline valid bit set.
- i_flush (sync, has priority over all other inputs except reset):
  - Next cycle: o_raddr=0, o_ren=0, all pipeline bits cleared (o_wr=0, o_sof=0), state=IDLE.
  - Data already in the FIFO is not this block's concern.
- i_flush and i_req both high: flush wins. The block enters ACTIVE no earlier than one cycle after flush deasserts.
- Addresses never exceed BRAM_DEPTH-1; o_ren is never high with an address out of range.

Test Plan:
(sim BRAM_DEPTH=16, RD_LATENCY=2, BRAM model with 2-cycle latency returning data=addr)
- Reset then i_req=1, almostfull=0 → o_ren high from cycle 2. o_wr first high 2 cycles later with data 0, o_sof=1 on that cycle. 16 writes, data 0..15 in order.
- i_req held high over 3 frames → continuous o_wr with no gaps. Data sequence 0..15,0..15,0..15. o_sof exactly 3 pulses, spaced 16 cycles apart.
- almostfull=1 for 5 cycles starting when o_raddr=6 → o_ren low for those 5 cycles, o_raddr holds 6, at most 2 further o_wr (data 4,5). Resumes at 6 with no skipped or duplicated data.
- i_req dropped at address 9 → frame completes through 15, then IDLE with o_raddr=0. o_busy falls 2 cycles after the last o_ren.
- i_flush pulsed at address 10 with 2 reads in flight → next cycle o_wr=0, o_raddr=0, IDLE. With i_req high, the restart streams from data 0 with o_sof.
- Async i_rst asserted mid-frame between clock edges → all outputs 0 immediately, without waiting for a clock edge. After release, behaviour matches a fresh start.
